fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's FIFO (`datain`/`w_en`/`full`) between `NREQ` producers on the write clock domain. Each producer is granted ownership for a burst of up to `BURST` words. The FIFO's `full` flag applies back-pressure. The block sits directly in front of the FIFO write side, and its outputs drive `w_en`/`datain`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (≥2)
- `DW`, 1, data width per word (matches FIFO `datain` width)
- `BURST`, 4, maximum words per grant (≥1)

Ports:
- `clk`  in  1  write-domain clock (connects to FIFO `w_clk`); all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester request; bit i held high while requester i has a word on its data slice
- `data`  in  NREQ*DW  requester i word at bits [i*DW +: DW]
- `gnt`  out  NREQ  one-hot accept strobe; word i is consumed on the rising edge where `gnt[i]`=1
- `fifo_full`  in  1  FIFO `full` flag
- `fifo_w_en`  out  1  FIFO write enable
- `fifo_datain`  out  DW  FIFO write data
- `owner`  out  clog2(NREQ)  current/last owner index (registered)
- `busy`  out  1  high while a requester owns the port

## Operation
- Registered state: `state` (IDLE/OWN), `owner`, `ptr` (round-robin start, clog2(NREQ)), `cnt` (words in current burst, width clog2(BURST), min 1).
- IDLE:
  - If any `req` is high, pick the first set bit scanning `ptr`, `ptr`+1, …, wrapping mod NREQ.
  - Load `owner` with that index, set `cnt`=0, and go to OWN.
  - No transfer occurs in the arbitration cycle.
- OWN, combinational outputs:
  - `gnt[owner]` = `req[owner]` & ~`fifo_full`; all other `gnt` bits are 0.
  - `fifo_w_en` = |`gnt`.
  - `fifo_datain` = `data` slice of `owner` when `fifo_w_en`=1, else 0.
- OWN, per edge:
  - Transfer with `cnt`==BURST-1: burst complete. Set `ptr`=(`owner`+1) mod NREQ, go to IDLE.
  - Transfer otherwise: `cnt`++, stay in OWN.
  - `req[owner]`=0 (no transfer possible): early release. Set `ptr`=(`owner`+1) mod NREQ, go to IDLE.
  - `req[owner]`=1 and `fifo_full`=1: stall. `cnt`, `owner` and `state` hold; there is no timeout.
- Requests from non-owners are ignored until the next IDLE cycle.
- `busy` = (`state`==OWN).
- Reset values: `state`=IDLE, `ptr`=0, `owner`=0, `cnt`=0. Consequently `gnt`=0, `fifo_w_en`=0, `fifo_datain`=0, `busy`=0.

## Timing
- Arbitration latency: 1 cycle from `req` sampled high in IDLE to `gnt` valid in OWN.
- Peak throughput: BURST words per BURST+1 cycles, because there is one IDLE bubble per ownership.
- `gnt`/`fifo_w_en` are combinational from registered state plus `req`/`fifo_full`. They respond in the same cycle to `fifo_full` rising, so no write occurs while `full`=1.
- BURST=1: every grant is a single word followed by IDLE.
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NREQ-1,0. No requester waits more than (NREQ-1)·(BURST+1) cycles after reaching IDLE arbitration.
- `ptr` wrap-around: `owner`=NREQ-1 releases → `ptr`=0.
- `fifo_full` and owner `req` deassert in the same cycle: the release rule wins, and the block goes to IDLE.
- `rst` low at any time: all registers clear immediately (asynchronously). `gnt`/`fifo_w_en` fall without waiting for `clk`. A burst in progress is abandoned; no partial-burst state survives.
- Reset release: first arbitration occurs on the first edge with `rst`=1 and any `req`=1.

## Test plan
- Reset: `rst`=0 with `req`=4'b1111 and `fifo_full`=0.
  - Required: `gnt`=0, `fifo_w_en`=0, `fifo_datain`=0, `busy`=0, `owner`=0.
- Single requester: `req`=4'b0001 held, alternating data 1,0,1,0,…, BURST=4.
  - Required: `fifo_w_en` pattern 0,1,1,1,1,0,1,1,1,1…
  - Required: `fifo_datain` 1,0,1,0 in each burst; `owner` stays 0.
- All active: `req`=4'b1111 held.
  - Required: `owner` sequence 0,1,2,3,0.
  - Required: exactly 4 writes per ownership with one idle cycle between ownerships.
- Back-pressure: `fifo_full`=1 for 3 cycles after the 2nd word of a burst.
  - Required: `gnt`/`fifo_w_en` low during those 3 cycles, `cnt` frozen, and exactly 4 words total in the burst.
- Early release: requester 1 drops `req` after 2 accepted words while requester 2 requests.
  - Required: IDLE on the next cycle, `ptr`=2, and requester 2 granted the following cycle.
- Mid-burst reset: `rst` pulsed low between edges during requester 2's 3rd word.
  - Required: `fifo_w_en` falls immediately.
  - Required: after release with `req`=4'b1111, requester 0 wins first (`ptr`=0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Owners hold the port for up to BURST words; fifo_full stalls, a dropped req releases.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 1,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [DW-1:0]            fifo_datain,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;
  int            pick_pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan starting at ptr, wrapping; the first requester seen wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pick_pos = (int'(ptr_q) + k) % NREQ;
      if (!pick_found && req[pick_pos]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(pick_pos);
      end
    end
  end

  assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt         = '0;
    fifo_w_en   = 1'b0;
    fifo_datain = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        // A dropped request releases even when the FIFO is also full.
        if (!req[owner_q]) begin
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end else if (!fifo_full) begin
          gnt[owner_q] = 1'b1;
          fifo_w_en    = 1'b1;
          fifo_datain  = data[owner_q*DW +: DW];
          if (cnt_q == CW'(BURST - 1)) begin
            ptr_d   = next_ptr;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign owner = owner_q;
  assign busy  = (state_q == S_OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed bench for fifo_wr_arbiter
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 1;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  data = '0;
  logic [NREQ-1:0]  gnt;
  logic             fifo_full = 1'b0;
  logic             fifo_w_en;
  logic [DW-1:0]    fifo_datain;
  logic [1:0]       owner;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .gnt         (gnt),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_datain (fifo_datain),
    .owner       (owner),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after an edge with all state cleared and ptr=0.
  task automatic do_reset();
    tick();
    req       = '0;
    fifo_full = 1'b0;
    rst       = 1'b0;
    #2;
    rst       = 1'b1;
  endtask

  initial begin
    int exp_own [5];
    logic exp_dat [4];
    exp_own = '{0, 1, 2, 3, 0};
    exp_dat = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state with all requests active
    rst = 1'b0; req = 4'b1111; fifo_full = 1'b0; data = 4'b1111;
    #1;
    check("rst_gnt",   gnt,         0);
    check("rst_wen",   fifo_w_en,   0);
    check("rst_dat",   fifo_datain, 0);
    check("rst_busy",  busy,        0);
    check("rst_owner", owner,       0);
    tick();
    check("rst_hold_wen", fifo_w_en, 0);
    check("rst_hold_busy", busy,     0);

    // Single requester, alternating data: w_en 0,1,1,1,1,0,1,1,1,1
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      data = {3'b000, ((c % 5) == 1 || (c % 5) == 3) ? 1'b1 : 1'b0};
      #1;
      check($sformatf("single_wen_%0d", c), fifo_w_en, (c % 5) != 0);
      check($sformatf("single_dat_%0d", c), fifo_datain,
            ((c % 5) == 1 || (c % 5) == 3) ? 1 : 0);
      check($sformatf("single_own_%0d", c), owner, 0);
      tick();
    end

    // All active: owners rotate 0,1,2,3,0 with 4 writes each and one idle between
    do_reset();
    req  = 4'b1111;
    data = 4'b1010;
    for (int o = 0; o < 5; o++) begin
      #1;
      check($sformatf("rr_idle_wen_%0d", o), fifo_w_en, 0);
      check($sformatf("rr_idle_busy_%0d", o), busy, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_own_%0d_%0d", o, k), owner, exp_own[o]);
        check($sformatf("rr_gnt_%0d_%0d", o, k), gnt, 32'd1 << exp_own[o]);
        check($sformatf("rr_dat_%0d_%0d", o, k), fifo_datain, exp_dat[exp_own[o]]);
        tick();
      end
    end

    // Back-pressure: full for 3 cycles after the 2nd word, burst still 4 words
    do_reset();
    req  = 4'b0001;
    data = 4'b0001;
    tick();
    check("bp_w1", fifo_w_en, 1);
    tick();
    check("bp_w2", fifo_w_en, 1);
    tick();
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("bp_stall_gnt_%0d", s), gnt, 0);
      check($sformatf("bp_stall_wen_%0d", s), fifo_w_en, 0);
      check($sformatf("bp_stall_busy_%0d", s), busy, 1);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    check("bp_w3", fifo_w_en, 1);
    tick();
    check("bp_w4", fifo_w_en, 1);
    tick();
    check("bp_end_wen", fifo_w_en, 0);
    check("bp_end_busy", busy, 0);

    // Early release by requester 1 with full also asserted; req0 tests ptr=2
    do_reset();
    req  = 4'b0110;
    data = 4'b0000;
    tick();
    check("er_gnt1", gnt, 4'b0010);
    tick();
    check("er_gnt2", gnt, 4'b0010);
    tick();
    req       = 4'b0101;
    fifo_full = 1'b1;
    #1;
    check("er_drop_gnt", gnt, 0);
    check("er_drop_busy", busy, 1);
    tick();
    fifo_full = 1'b0;
    #1;
    check("er_idle_busy", busy, 0);
    check("er_idle_wen", fifo_w_en, 0);
    tick();
    check("er_next_owner", owner, 2);
    check("er_next_gnt", gnt, 4'b0100);

    // Mid-burst asynchronous reset during requester 2's 3rd word
    do_reset();
    req  = 4'b0100;
    data = 4'b0100;
    tick();
    tick();
    tick();
    check("mr_w3_wen", fifo_w_en, 1);
    check("mr_w3_gnt", gnt, 4'b0100);
    #1;
    rst = 1'b0;
    #1;
    check("mr_async_wen", fifo_w_en, 0);
    check("mr_async_gnt", gnt, 0);
    check("mr_async_busy", busy, 0);
    req = 4'b1111;
    #1;
    rst = 1'b1;
    tick();
    check("mr_after_owner", owner, 0);
    check("mr_after_gnt", gnt, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
